// File: rtl/dmem_dma_if.sv
// Bus bundle for dmem_dma: transfer request/status plus the two memory ports.
// The slave modport is the DMA engine; the master modport is the requester and
// memory side that drives requests and read data.
interface dmem_dma_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [ADDR_WIDTH:0]   len;
    logic                  fill_en;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic                  we_a;
    logic [DATA_WIDTH-1:0] wdata_a;
    logic [DATA_WIDTH-1:0] rdata_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  we_b;
    logic [DATA_WIDTH-1:0] wdata_b;
    logic [DATA_WIDTH-1:0] rdata_b;

    modport slave (
        input  start, src_addr, dst_addr, len, fill_en, fill_data, rdata_a, rdata_b,
        output busy, done, addr_a, we_a, wdata_a, addr_b, we_b, wdata_b
    );

    modport master (
        output start, src_addr, dst_addr, len, fill_en, fill_data, rdata_a, rdata_b,
        input  busy, done, addr_a, we_a, wdata_a, addr_b, we_b, wdata_b
    );
endinterface

// File: rtl/dmem_dma.sv
// dmem_dma: word-at-a-time memory copy engine over a dual-port RAM.
// Port A issues reads (one-cycle read latency), port B performs writes, giving
// one word per cycle with no bubbles. Optional fill mode (macro DMA_FILL_EN)
// writes a constant word without reading; when the macro is undefined the
// fill inputs are ignored and every transfer is a copy.
//
// state | meaning
// IDLE  | waiting for start; request inputs sampled here only
// RUN   | copy: reads being issued (writes trail by one cycle); fill: writes
// DRAIN | copy only: final write, no more reads
// DONE  | one-cycle completion pulse, then back to IDLE
module dmem_dma #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_dma_if.slave   bus
);

`ifdef DMA_FILL_EN
    localparam bit FILL_SUPPORTED = 1'b1;
`else
    localparam bit FILL_SUPPORTED = 1'b0;
`endif

    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic                  we_b_q, we_b_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fill_q, fill_d;
    logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
    logic                  fill_req;
    logic                  unused_rdata_b;

    assign fill_req       = FILL_SUPPORTED & bus.fill_en;
    assign unused_rdata_b = ^bus.rdata_b;

    // Next-state and next-output computation; rem counts reads (copy) or
    // writes (fill) still to issue after the current one.
    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        rem_d    = rem_q;
        we_b_d   = we_b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        fill_d   = fill_q;
        fdata_d  = fdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    fill_d   = fill_req;
                    fdata_d  = bus.fill_data;
                    addr_b_d = bus.dst_addr;
                    if (bus.len == LEN_ZERO) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        rem_d   = bus.len - LEN_ONE;
                        we_b_d  = fill_req;
                        if (!fill_req) begin
                            addr_a_d = bus.src_addr;
                        end
                    end
                end
            end
            S_RUN: begin
                if (fill_q) begin
                    if (rem_q == LEN_ZERO) begin
                        state_d = S_DONE;
                        we_b_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        rem_d    = rem_q - LEN_ONE;
                        addr_b_d = addr_b_q + ADDR_ONE;
                    end
                end else begin
                    // The first write trails the first read, so the write
                    // address only advances once writing is under way.
                    we_b_d = 1'b1;
                    if (we_b_q) begin
                        addr_b_d = addr_b_q + ADDR_ONE;
                    end
                    if (rem_q == LEN_ZERO) begin
                        state_d = S_DRAIN;
                    end else begin
                        rem_d    = rem_q - LEN_ONE;
                        addr_a_d = addr_a_q + ADDR_ONE;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                we_b_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                we_b_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_a_q <= '0;
            addr_b_q <= '0;
            rem_q    <= '0;
            we_b_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fill_q   <= 1'b0;
            fdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            rem_q    <= rem_d;
            we_b_q   <= we_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fill_q   <= fill_d;
            fdata_q  <= fdata_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.addr_a  = addr_a_q;
    assign bus.we_a    = 1'b0;
    assign bus.wdata_a = '0;
    assign bus.addr_b  = addr_b_q;
    assign bus.we_b    = we_b_q;
    assign bus.wdata_b = fill_q ? fdata_q : bus.rdata_a;

endmodule

// File: tb/tb_dmem_dma.sv
// Directed testbench for dmem_dma with a synchronous-read dual-port RAM model.
module tb_dmem_dma;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk;
    logic rst_n;
    logic load;
    int   checks;
    int   errors;
    int   viol;
    int   busy_c, done_c, done_n, wr_c;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    dmem_dma_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dmem_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: port A read with one-cycle latency, port B write; load restores mem[i]=i.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i);
        end else if (bus.we_b) begin
            mem[bus.addr_b] <= bus.wdata_b;
        end
        bus.rdata_a <= mem[bus.addr_a];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reload();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Issue one start, then observe cycle by cycle (cycle j lies between E(j-1) and Ej).
    // restart_at: pulse a second start during that cycle; rst_at: assert reset in that cycle.
    task automatic run(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [AW:0] n,
                       input logic fe, input int restart_at, input int rst_at);
        busy_c = 0; done_c = 0; done_n = 0; wr_c = 0;
        @(negedge clk);
        bus.src_addr = src;
        bus.dst_addr = dst;
        bus.len      = n;
        bus.fill_en  = fe;
        bus.start    = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 1) bus.start = 1'b0;
            if (restart_at != 0 && j == restart_at) begin
                bus.src_addr = 10'h000;
                bus.dst_addr = 10'h300;
                bus.len      = 11'd2;
                bus.start    = 1'b1;
            end
            if (restart_at != 0 && j == restart_at + 1) bus.start = 1'b0;
            if (rst_at != 0 && j == rst_at + 1) begin
                chk("abort_busy", {63'd0, bus.busy}, 64'd0);
                chk("abort_done", {63'd0, bus.done}, 64'd0);
                rst_n = 1'b1;
            end
            if (rst_at != 0 && j == rst_at) rst_n = 1'b0;
            if (bus.busy) busy_c++;
            if (bus.we_b) wr_c++;
            if (bus.we_b && !bus.busy) viol++;
            if (bus.done) begin
                done_n++;
                if (done_c == 0) done_c = j;
            end
            if (done_c != 0 && j >= done_c + 3) break;
        end
    endtask

    initial begin
        checks = 0; errors = 0; viol = 0;
        rst_n = 1'b0; load = 1'b0;
        bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;
        bus.fill_en = 1'b0; bus.fill_data = 32'hDEADBEEF; bus.rdata_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_we_b", {63'd0, bus.we_b}, 64'd0);
        chk("rst_addr_a", 64'(bus.addr_a), 64'd0);
        chk("rst_addr_b", 64'(bus.addr_b), 64'd0);
        chk("rst_we_a", {63'd0, bus.we_a}, 64'd0);
        rst_n = 1'b1;

        // Basic copy 0x010 -> 0x100, 4 words
        reload();
        run(10'h010, 10'h100, 11'd4, 1'b0, 0, 0);
        chk("cp_busy_cycles", 64'(busy_c), 64'd5);
        chk("cp_done_cycle", 64'(done_c), 64'd6);
        chk("cp_done_count", 64'(done_n), 64'd1);
        chk("cp_writes", 64'(wr_c), 64'd4);
        for (int i = 0; i < 4; i++) chk("cp_data", 64'(mem[10'h100 + i]), 64'(32'h10 + i));
        chk("cp_untouched", 64'(mem[10'h104]), 64'h104);

        // Source wraps past the top of memory
        reload();
        run(10'h3FE, 10'h200, 11'd4, 1'b0, 0, 0);
        chk("wrap_src_done", 64'(done_c), 64'd6);
        chk("wrap_src_w0", 64'(mem[10'h200]), 64'h3FE);
        chk("wrap_src_w1", 64'(mem[10'h201]), 64'h3FF);
        chk("wrap_src_w2", 64'(mem[10'h202]), 64'h000);
        chk("wrap_src_w3", 64'(mem[10'h203]), 64'h001);

        // Destination wraps past the top of memory
        reload();
        run(10'h010, 10'h3FE, 11'd4, 1'b0, 0, 0);
        chk("wrap_dst_w0", 64'(mem[10'h3FE]), 64'h10);
        chk("wrap_dst_w1", 64'(mem[10'h3FF]), 64'h11);
        chk("wrap_dst_w2", 64'(mem[10'h000]), 64'h12);
        chk("wrap_dst_w3", 64'(mem[10'h001]), 64'h13);

        // Zero-length transfer
        reload();
        run(10'h010, 10'h100, 11'd0, 1'b0, 0, 0);
        chk("len0_writes", 64'(wr_c), 64'd0);
        chk("len0_busy", 64'(busy_c), 64'd0);
        chk("len0_done_cycle", 64'(done_c), 64'd1);
        chk("len0_done_count", 64'(done_n), 64'd1);

        // Second start while busy is ignored
        reload();
        run(10'h020, 10'h180, 11'd8, 1'b0, 3, 0);
        chk("busy_start_done_count", 64'(done_n), 64'd1);
        chk("busy_start_writes", 64'(wr_c), 64'd8);
        chk("busy_start_busy", 64'(busy_c), 64'd9);
        chk("busy_start_last", 64'(mem[10'h187]), 64'h27);
        chk("busy_start_no_queue", 64'(mem[10'h300]), 64'h300);

        // Start during the DONE cycle is ignored
        run(10'h030, 10'h190, 11'd2, 1'b0, 4, 0);
        chk("done_start_done_count", 64'(done_n), 64'd1);
        chk("done_start_writes", 64'(wr_c), 64'd2);
        chk("done_start_no_queue", 64'(mem[10'h300]), 64'h300);

        // Reset at E3 of an 8-word copy aborts it
        reload();
        run(10'h050, 10'h1C0, 11'd8, 1'b0, 0, 3);
        chk("abort_writes", 64'(wr_c), 64'd2);
        chk("abort_done_count", 64'(done_n), 64'd0);
        chk("abort_w0", 64'(mem[10'h1C0]), 64'h50);
        chk("abort_w1", 64'(mem[10'h1C1]), 64'h51);
        chk("abort_w2", 64'(mem[10'h1C2]), 64'h1C2);
        chk("abort_addr_a", 64'(bus.addr_a), 64'd0);

        // Overlapping move with dst < src
        reload();
        run(10'h040, 10'h03F, 11'd4, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) chk("overlap", 64'(mem[10'h03F + i]), 64'(32'h40 + i));

        // Fill request: real fill with the macro, plain copy without it
        reload();
        run(10'h070, 10'h020, 11'd3, 1'b1, 0, 0);
        chk("fill_writes", 64'(wr_c), 64'd3);
        chk("fill_done_count", 64'(done_n), 64'd1);
`ifdef DMA_FILL_EN
        chk("fill_done_cycle", 64'(done_c), 64'd4);
        chk("fill_busy", 64'(busy_c), 64'd3);
        chk("fill_addr_a", 64'(bus.addr_a), 64'h043);
        for (int i = 0; i < 3; i++) chk("fill_data", 64'(mem[10'h020 + i]), 64'hDEADBEEF);
`else
        chk("fill_done_cycle", 64'(done_c), 64'd5);
        chk("fill_busy", 64'(busy_c), 64'd4);
        for (int i = 0; i < 3; i++) chk("fill_as_copy", 64'(mem[10'h020 + i]), 64'(32'h70 + i));
`endif
        chk("fill_untouched", 64'(mem[10'h023]), 64'h023);

        chk("we_b_without_busy", 64'(viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
